sd_init_sequencer: RTL

//   Sequences SPI-mode SD card initialisation over a command/response engine that serialises 48-bit frames.

---
 rtl/sd_init_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card initialisation sequencer: dummy clocks, CMD0, CMD8, then CMD55+ACMD41 polling.
// Drives 48-bit command frames to a serialising engine and reports done/error with a cause code.
module sd_init_sequencer #(
   parameter int CMD0_RETRIES = 8,
   parameter int ACMD41_POLLS = 1000,
   parameter int POLL_WIDTH   = 16,
   parameter bit HCS          = 1'b1
) (
   input  logic                  input_clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  dummy_req,
   input  logic                  dummy_done,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [47:0]           cmd_frame,
   input  logic                  resp_valid,
   input  logic [7:0]            resp_r1,
   input  logic [31:0]           resp_r7,
   input  logic                  resp_timeout,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [2:0]            error_code,
   output logic                  card_v2,
   output logic [POLL_WIDTH-1:0] poll_count
);

   localparam int C0W = (CMD0_RETRIES < 2) ? 1 : $clog2(CMD0_RETRIES + 1);
   localparam logic [C0W-1:0]        C0_LIMIT   = C0W'(CMD0_RETRIES);
   localparam logic [POLL_WIDTH-1:0] POLL_LIMIT = POLL_WIDTH'(ACMD41_POLLS);

   localparam logic [47:0] FRAME_CMD0    = 48'h40_0000_0000_95;
   localparam logic [47:0] FRAME_CMD8    = 48'h48_0000_01AA_87;
   localparam logic [47:0] FRAME_CMD55   = 48'h77_0000_0000_65;
   localparam logic [47:0] FRAME_A41_HCS = 48'h69_4000_0000_77;
   localparam logic [47:0] FRAME_A41     = 48'h69_0000_0000_E5;

   typedef enum logic [3:0] {
      S_IDLE, S_DUMMY, S_CMD0, S_W0, S_CMD8, S_W8,
      S_CMD55, S_W55, S_A41, S_W41, S_DONE, S_ERR
   } state_t;

   state_t                  state, state_n;
   logic [C0W-1:0]          cmd0_cnt, cmd0_cnt_n;
   logic [POLL_WIDTH-1:0]   poll_n;
   logic [2:0]              code_n;
   logic                    v2_n;

   // Only the low 12 bits of the R7 tail carry the voltage/check pattern.
   logic unused_r7;
   assign unused_r7 = ^resp_r7[31:12];

   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         cmd0_cnt   <= '0;
         poll_count <= '0;
         error_code <= '0;
         card_v2    <= 1'b0;
      end else begin
         state      <= state_n;
         cmd0_cnt   <= cmd0_cnt_n;
         poll_count <= poll_n;
         error_code <= code_n;
         card_v2    <= v2_n;
      end
   end

   // Request outputs decode straight from state so reset removes them without waiting for a clock.
   assign busy  = !(state == S_IDLE || state == S_DONE || state == S_ERR);
   assign done  = (state == S_DONE);
   assign error = (state == S_ERR);

   always_comb begin
      state_n    = state;
      cmd0_cnt_n = cmd0_cnt;
      poll_n     = poll_count;
      code_n     = error_code;
      v2_n       = card_v2;
      dummy_req  = 1'b0;
      cmd_valid  = 1'b0;
      cmd_frame  = '0;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_n    = S_DUMMY;
               cmd0_cnt_n = '0;
               poll_n     = '0;
               code_n     = '0;
               v2_n       = 1'b0;
            end
         end
         S_DUMMY: begin
            dummy_req = 1'b1;
            if (dummy_done) state_n = S_CMD0;
         end
         S_CMD0: begin
            cmd_valid = 1'b1;
            cmd_frame = FRAME_CMD0;
            if (cmd_ready) state_n = S_W0;
         end
         S_W0: begin
            if (resp_valid && resp_r1 == 8'h01) begin
               state_n = S_CMD8;
            end else if (resp_valid || resp_timeout) begin
               cmd0_cnt_n = cmd0_cnt + C0W'(1);
               if (cmd0_cnt_n == C0_LIMIT) begin
                  state_n = S_ERR;
                  code_n  = 3'd1;
               end else begin
                  state_n = S_CMD0;
               end
            end
         end
         S_CMD8: begin
            cmd_valid = 1'b1;
            cmd_frame = FRAME_CMD8;
            if (cmd_ready) state_n = S_W8;
         end
         S_W8: begin
            if (resp_valid && resp_r1 == 8'h01 && resp_r7[11:0] == 12'h1AA) begin
               v2_n    = 1'b1;
               state_n = S_CMD55;
            end else if (resp_valid && resp_r1[2]) begin
               v2_n    = 1'b0;
               state_n = S_CMD55;
            end else if (resp_valid || resp_timeout) begin
               state_n = S_ERR;
               code_n  = 3'd2;
            end
         end
         S_CMD55: begin
            cmd_valid = 1'b1;
            cmd_frame = FRAME_CMD55;
            if (cmd_ready) state_n = S_W55;
         end
         S_W55: begin
            if (resp_valid && (resp_r1 == 8'h00 || resp_r1 == 8'h01)) begin
               state_n = S_A41;
            end else if (resp_valid || resp_timeout) begin
               state_n = S_ERR;
               code_n  = 3'd3;
            end
         end
         S_A41: begin
            cmd_valid = 1'b1;
            cmd_frame = (HCS && card_v2) ? FRAME_A41_HCS : FRAME_A41;
            if (cmd_ready) begin
               state_n = S_W41;
               if (poll_count != '1) poll_n = poll_count + POLL_WIDTH'(1);
            end
         end
         S_W41: begin
            if (resp_valid) begin
               if (resp_r1 == 8'h00) begin
                  state_n = S_DONE;
               end else if (resp_r1 == 8'h01) begin
                  if (poll_count == POLL_LIMIT) begin
                     state_n = S_ERR;
                     code_n  = 3'd4;
                  end else begin
                     state_n = S_CMD55;
                  end
               end else begin
                  state_n = S_ERR;
                  code_n  = 3'd5;
               end
            end else if (resp_timeout) begin
               state_n = S_ERR;
               code_n  = 3'd5;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule
